multicycle_ctrl: RTL and testbench

//  Main control FSM sequencing the shared decoder/regfile/ALU datapath of top_stage as a multicycle RV32I core.

---
 rtl/multicycle_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM that sequences the shared decoder /
// register file / ALU datapath as a multicycle RV32I core. It also keeps
// free-running cycle and retired-instruction counters for bring-up.
// Optional build macro: ILLEGAL_TRAP_EN -- when defined, undecodable
// instructions park the FSM in TRAP and raise the sticky illegal flag;
// when undefined they are skipped as NOPs (PC has already advanced).
module multicycle_ctrl #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic               func7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_op,
  output logic [2:0]         imm_src,
  output logic               illegal,
  output logic [COUNT_W-1:0] cycle_count,
  output logic [COUNT_W-1:0] instret_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

`ifdef ILLEGAL_TRAP_EN
  localparam state_t S_ILL_NEXT = S_TRAP;
`else
  localparam state_t S_ILL_NEXT = S_FETCH;
`endif

  state_t             state_r;
  state_t             state_next_s;
  logic               retire_s;
  logic               set_illegal_s;
  logic               taken_s;
  logic               illegal_r;
  logic [COUNT_W-1:0] cycle_r;
  logic [COUNT_W-1:0] instret_r;
  logic               unused_func7b5_s;

  // func7b5 is decoded by the ALU control block, not by this FSM.
  assign unused_func7b5_s = func7b5;

  // Branch decision: beq/bne use the SUB zero flag, blt/bge(u) use the SLT result.
  assign taken_s = func3[2] ? (~zero ^ func3[0]) : (zero ^ func3[0]);

  assign illegal       = illegal_r;
  assign cycle_count   = cycle_r;
  assign instret_count = instret_r;

  // Next-state decode and retire detection.
  always_comb begin
    state_next_s = state_r;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) begin
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
          OP_R:              state_next_s = S_EXECR;
          OP_I:              state_next_s = S_EXECI;
          OP_BRANCH: begin
            if (func3[2:1] == 2'b01) begin
              state_next_s = S_ILL_NEXT;
            end else begin
              state_next_s = S_BRANCH;
            end
          end
          OP_JAL:            state_next_s = S_JAL;
          OP_JALR:           state_next_s = S_JALR;
          OP_LUI:            state_next_s = S_LUI;
          default:           state_next_s = S_ILL_NEXT;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_STORE) begin
          state_next_s = S_MEMWRITE;
        end else begin
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        if (mem_ready) begin
          state_next_s = S_MEMWB;
        end else begin
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        state_next_s = S_FETCH;
        retire_s     = 1'b1;
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_next_s = S_FETCH;
          retire_s     = 1'b1;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_EXECR:  state_next_s = S_ALUWB;
      S_EXECI:  state_next_s = S_ALUWB;
      S_ALUWB: begin
        state_next_s = S_FETCH;
        retire_s     = 1'b1;
      end
      S_BRANCH: begin
        state_next_s = S_FETCH;
        retire_s     = 1'b1;
      end
      S_JAL:    state_next_s = S_ALUWB;
      S_JALR:   state_next_s = S_JAL;
      S_LUI:    state_next_s = S_ALUWB;
      S_TRAP:   state_next_s = S_TRAP;
      default:  state_next_s = S_FETCH;
    endcase
  end

  // Sticky illegal flag is raised on entry to TRAP (never in the NOP build).
  always_comb begin
`ifdef ILLEGAL_TRAP_EN
    set_illegal_s = (state_next_s == S_TRAP);
`else
    set_illegal_s = 1'b0;
`endif
  end

  // Datapath controls: per-state selects plus Mealy fetch/branch strobes, all forced low in reset.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    imm_src    = 3'b000;
    if (reset) begin
      case (state_r)
        S_FETCH: begin
          mem_req    = 1'b1;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = 3'b010;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          if (opcode == OP_STORE) begin
            imm_src = 3'b001;
          end else begin
            imm_src = 3'b000;
          end
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          result_src = 2'b01;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 2'b10;
          pc_write  = taken_s;
          if (func3[2]) begin
            alu_op = 2'b10;
          end else begin
            alu_op = 2'b01;
          end
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_JALR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_LUI: begin
          alu_src_a = 2'b11;
          alu_src_b = 2'b01;
          imm_src   = 3'b100;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end else begin
      mem_req = 1'b0;
    end
  end

  // State register; reset aborts any access in flight and restarts at FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Free-running cycle and retired-instruction counters, wrapping silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_r   <= '0;
      instret_r <= '0;
    end else begin
      cycle_r <= cycle_r + COUNT_W'(1);
      if (retire_s) begin
        instret_r <= instret_r + COUNT_W'(1);
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  // Sticky illegal-instruction flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= illegal_r | set_illegal_s;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A reference model builds, per
// instruction, the expected cycle-by-cycle control vector from the
// instruction class, memory wait plan and branch outcome; a second instance
// with COUNT_W=4 checks counter wrap.
module tb_multicycle_ctrl;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_JALR = 6, K_LUI = 7, K_ILL = 8;
  localparam logic [17:0] M_ALL = 18'h3FFFF;
  localparam logic [17:0] M_CTL = 18'h3F800;

  logic clk = 1'b0;
  logic reset, func7b5, zero, mem_ready;
  logic [6:0] opcode;
  logic [2:0] func3;

  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [2:0] imm_src;
  logic [31:0] cycle_count, instret_count;

  logic mem_req4, mem_write4, adr_src4, ir_write4, pc_write4, reg_write4, illegal4;
  logic [1:0] alu_src_a4, alu_src_b4, result_src4, alu_op4;
  logic [2:0] imm_src4;
  logic [3:0] cycle_count4, instret_count4;

  logic [17:0] obs_s, obs4_s;
  logic [17:0] q_exp[$];
  logic [17:0] q_msk[$];
  int          q_rdy[$];
  int          n_assert = 0, n_fail = 0, ncyc = 0;
  logic [31:0] exp_instret = 32'd0;
  logic        exp_illegal = 1'b0;
  logic [2:0]  br_f3 [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

  always #5 clk = ~clk;

  multicycle_ctrl #(.COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7b5(func7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .imm_src(imm_src), .illegal(illegal), .cycle_count(cycle_count), .instret_count(instret_count)
  );

  multicycle_ctrl #(.COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7b5(func7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req4), .mem_write(mem_write4),
    .adr_src(adr_src4), .ir_write(ir_write4), .pc_write(pc_write4), .reg_write(reg_write4),
    .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .result_src(result_src4), .alu_op(alu_op4),
    .imm_src(imm_src4), .illegal(illegal4), .cycle_count(cycle_count4), .instret_count(instret_count4)
  );

  assign obs_s  = {illegal, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, result_src, alu_op, imm_src};
  assign obs4_s = {illegal4, mem_req4, mem_write4, adr_src4, ir_write4, pc_write4, reg_write4,
                   alu_src_a4, alu_src_b4, result_src4, alu_op4, imm_src4};

  function automatic logic [17:0] mk(input logic il, input logic mr, input logic mw, input logic as,
                                     input logic iw, input logic pw, input logic rw, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] res, input logic [1:0] op,
                                     input logic [2:0] imm);
    return {il, mr, mw, as, iw, pw, rw, a, b, res, op, imm};
  endfunction

  // Branch outcome from the mnemonic: zero is the SUB result for beq/bne, the SLT result for the rest.
  function automatic logic br_taken(input logic [2:0] f3, input logic z);
    case (f3)
      3'b000:          return z;
      3'b001:          return !z;
      3'b100, 3'b110:  return !z;
      3'b101, 3'b111:  return z;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] op_of(input int kind);
    case (kind)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LD:    return 7'b0000011;
      K_ST:    return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      K_LUI:   return 7'b0110111;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    ncyc++;
    #1;
  endtask

  task automatic push(input logic [17:0] e, input logic [17:0] m, input int r);
    q_exp.push_back(e);
    q_msk.push_back(m);
    q_rdy.push_back(r);
  endtask

  task automatic check_counts(input string tag);
    n_assert++;
    assert ({instret_count, cycle_count, instret_count4, cycle_count4} ===
            {exp_instret, 32'(ncyc), exp_instret[3:0], 4'(ncyc)})
    else begin
      n_fail++;
      $error("FAIL %s: observed instret=%0d cycles=%0d w4=%0d/%0d expected instret=%0d cycles=%0d",
             tag, instret_count, cycle_count, instret_count4, cycle_count4, exp_instret, ncyc);
    end
  endtask

  // Runs one instruction from FETCH: builds the expected per-cycle vectors, then drives and checks them.
  task automatic run_instr(input string name, input int kind, input logic [6:0] op7, input logic [2:0] f3,
                           input int wf, input int wm, input logic z);
    logic il;
    logic tk;
    logic [1:0] bop;
    logic [17:0] e, m, wb;
    int r, cyc;
    il = exp_illegal;
    opcode = op7;
    func3 = f3;
    func7b5 = 1'($urandom_range(0, 1));
    zero = z;
    q_exp.delete(); q_msk.delete(); q_rdy.delete();
    wb = mk(il, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    for (int i = 0; i < wf; i++)
      push(mk(il, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), M_CTL, 0);
    push(mk(il, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), M_ALL, 1);
    push(mk(il, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b010), M_ALL, 2);
    case (kind)
      K_R: begin
        push(mk(il, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 3'b000), M_ALL, 2);
        push(wb, M_ALL, 2);
      end
      K_I: begin
        push(mk(il, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b10, 3'b000), M_ALL, 2);
        push(wb, M_ALL, 2);
      end
      K_LD: begin
        push(mk(il, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000), M_ALL, 2);
        e = mk(il, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        for (int i = 0; i < wm; i++) push(e, M_ALL, 0);
        push(e, M_ALL, 1);
        push(mk(il, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000), M_ALL, 2);
      end
      K_ST: begin
        push(mk(il, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b001), M_ALL, 2);
        e = mk(il, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        for (int i = 0; i < wm; i++) push(e, M_ALL, 0);
        push(e, M_ALL, 1);
      end
      K_BR: begin
        tk = br_taken(f3, z);
        bop = f3[2] ? 2'b10 : 2'b01;
        push(mk(il, 1'b0, 1'b0, 1'b0, 1'b0, tk, 1'b0, 2'b10, 2'b00, 2'b00, bop, 3'b000), M_ALL, 2);
      end
      K_JAL, K_JALR: begin
        if (kind == K_JALR)
          push(mk(il, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000), M_ALL, 2);
        push(mk(il, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000), M_ALL, 2);
        push(wb, M_ALL, 2);
      end
      K_LUI: begin
        push(mk(il, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 3'b100), M_ALL, 2);
        push(wb, M_ALL, 2);
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) push(18'h20000, M_ALL, 2);
`endif
      end
    endcase
    cyc = 0;
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      m = q_msk.pop_front();
      r = q_rdy.pop_front();
      mem_ready = (r == 2) ? 1'($urandom_range(0, 1)) : 1'(r);
      @(negedge clk);
      n_assert++;
      assert ({obs_s & m, obs4_s & m} === {e & m, e & m})
      else begin
        n_fail++;
        $error("FAIL %s cyc%0d: observed %h (w4 %h) expected %h mask %h", name, cyc, obs_s, obs4_s, e, m);
      end
      cyc++;
      tick();
    end
    if (kind != K_ILL) exp_instret = exp_instret + 32'd1;
`ifdef ILLEGAL_TRAP_EN
    if (kind == K_ILL) exp_illegal = 1'b1;
`endif
    check_counts({name, "_counts"});
  endtask

  task automatic check_zero(input string tag);
    n_assert++;
    assert ({obs_s, obs4_s, cycle_count, instret_count, cycle_count4, instret_count4} === '0)
    else begin
      n_fail++;
      $error("FAIL %s: observed ctl=%h w4=%h cyc=%0d ret=%0d expected all zero",
             tag, obs_s, obs4_s, cycle_count, instret_count);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    check_zero("reset_async");
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("reset_hold");
    reset = 1'b1;
    ncyc = 0;
    exp_instret = 32'd0;
    exp_illegal = 1'b0;
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b0; opcode = 7'd0; func3 = 3'd0; func7b5 = 1'b0; zero = 1'b0;
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b1;
    ncyc = 0;

    // FETCH holds for 16 cycles without mem_ready; the 4-bit counter wraps to 0.
    for (int i = 0; i < 16; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      n_assert++;
      assert ((obs_s & M_CTL) === 18'h10000)
      else begin n_fail++; $error("FAIL fetch_hold: observed %h expected %h", obs_s & M_CTL, 18'h10000); end
      tick();
    end
    n_assert++;
    assert ({cycle_count4, cycle_count} === {4'd0, 32'd16})
    else begin n_fail++; $error("FAIL wrap4: observed %0d/%0d expected 0/16", cycle_count4, cycle_count); end

    // Directed instructions.
    run_instr("add",  K_R,    op_of(K_R),    3'b000, 0, 0, 1'b0);
    run_instr("lw",   K_LD,   op_of(K_LD),   3'b010, 0, 3, 1'b0);
    run_instr("beq",  K_BR,   op_of(K_BR),   3'b000, 0, 0, 1'b1);
    run_instr("bne",  K_BR,   op_of(K_BR),   3'b001, 0, 0, 1'b1);
    run_instr("blt",  K_BR,   op_of(K_BR),   3'b100, 0, 0, 1'b0);
    run_instr("sw",   K_ST,   op_of(K_ST),   3'b010, 1, 2, 1'b0);
    run_instr("addi", K_I,    op_of(K_I),    3'b000, 2, 0, 1'b0);
    run_instr("jal",  K_JAL,  op_of(K_JAL),  3'b000, 0, 0, 1'b0);
    run_instr("jalr", K_JALR, op_of(K_JALR), 3'b000, 0, 0, 1'b0);
    run_instr("lui",  K_LUI,  op_of(K_LUI),  3'b000, 0, 0, 1'b0);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      int k;
      logic [6:0] op7;
      logic [2:0] f3;
`ifdef ILLEGAL_TRAP_EN
      k = $urandom_range(0, 7);
`else
      k = $urandom_range(0, 8);
`endif
      op7 = op_of(k);
      f3 = 3'($urandom_range(0, 7));
      if (k == K_BR) f3 = br_f3[$urandom_range(0, 5)];
      if (k == K_ILL && $urandom_range(0, 1) == 1) begin
        op7 = op_of(K_BR);
        f3 = {2'b01, 1'($urandom_range(0, 1))};
      end
      run_instr($sformatf("rnd%0d", n), k, op7, f3, $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)));
    end

    // Undecodable opcode: trap and park, or skip as a NOP.
    run_instr("ill7f", K_ILL, 7'h7F, 3'b000, 0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    do_reset();
`endif
    run_instr("add2", K_R, op_of(K_R), 3'b000, 0, 0, 1'b0);

    // Reset pulse while a load waits in MEMREAD.
    opcode = op_of(K_LD); func3 = 3'b010; zero = 1'b0;
    mem_ready = 1'b1; tick();
    mem_ready = 1'b0; tick();
    tick();
    @(negedge clk);
    n_assert++;
    assert (obs_s === mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000))
    else begin n_fail++; $error("FAIL memread_wait: observed %h expected %h", obs_s, 18'h14000); end
    #2;
    do_reset();
    run_instr("add_after_reset", K_R, op_of(K_R), 3'b000, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
